// File: rtl/cpu6_ifid_buf.sv
// rtl/cpu6_ifid_buf.sv - decode-side instruction FIFO with write-time immediate-format classification
//
// Ports:
//   clk, resetn                 rising-edge clock, synchronous active-low reset
//   f_valid/f_ready/f_instr/f_pc
//                               fetch-side handshake and payload
//   flush                       discards every buffered and in-flight instruction
//   d_valid/d_ready             decode-side handshake
//   d_instr/d_pc/d_immtype/d_illegal
//                               head entry, all zero while d_valid=0
module cpu6_ifid_buf #(
    parameter int DEPTH                = 2,
    parameter int PTR_W                = 1,
    parameter int CPU6_XLEN            = 32,
    parameter int CPU6_BRANCHTYPE_SIZE = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            f_valid,
    output logic                            f_ready,
    input  logic [31:0]                     f_instr,
    input  logic [CPU6_XLEN-1:0]            f_pc,
    input  logic                            flush,
    output logic                            d_valid,
    input  logic                            d_ready,
    output logic [31:0]                     d_instr,
    output logic [CPU6_XLEN-1:0]            d_pc,
    output logic [CPU6_BRANCHTYPE_SIZE-1:0] d_immtype,
    output logic                            d_illegal
);

    localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_IMMTYPE_NONE = CPU6_BRANCHTYPE_SIZE'(0);
    localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_IMMTYPE_I    = CPU6_BRANCHTYPE_SIZE'(1);
    localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_IMMTYPE_S    = CPU6_BRANCHTYPE_SIZE'(2);
    localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_IMMTYPE_B    = CPU6_BRANCHTYPE_SIZE'(3);

    logic [31:0]                     instr_mem   [DEPTH];
    logic [CPU6_XLEN-1:0]            pc_mem      [DEPTH];
    logic [CPU6_BRANCHTYPE_SIZE-1:0] immtype_mem [DEPTH];
    logic                            illegal_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic                            full;
    logic                            push;
    logic                            pop;
    logic [CPU6_BRANCHTYPE_SIZE-1:0] wr_immtype;
    logic                            wr_illegal;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    // No d_ready term here: keeps decode stall off the fetch timing path.
    assign f_ready = !full && !flush && resetn;
    assign d_valid = (count != '0);
    assign push    = f_valid && f_ready;
    assign pop     = d_valid && d_ready && !flush;

    // Classify on the way in so the immediate decoder sees a registered select.
    // Every recognised opcode ends in 2'b11, so compressed/bad encodings fall to default.
    always_comb begin
        wr_immtype = CPU6_IMMTYPE_NONE;
        wr_illegal = 1'b0;
        case (f_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b1110011, 7'b0001111:             wr_immtype = CPU6_IMMTYPE_I;
            7'b0100011:                         wr_immtype = CPU6_IMMTYPE_S;
            7'b1100011:                         wr_immtype = CPU6_IMMTYPE_B;
            7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111:             wr_immtype = CPU6_IMMTYPE_NONE;
            default:                            wr_illegal = 1'b1;
        endcase
    end

    // Storage needs no reset; entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr]   <= f_instr;
            pc_mem[wr_ptr]      <= f_pc;
            immtype_mem[wr_ptr] <= wr_immtype;
            illegal_mem[wr_ptr] <= wr_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
        end
    end

    assign d_instr   = d_valid ? instr_mem[rd_ptr]   : '0;
    assign d_pc      = d_valid ? pc_mem[rd_ptr]      : '0;
    assign d_immtype = d_valid ? immtype_mem[rd_ptr] : CPU6_IMMTYPE_NONE;
    assign d_illegal = d_valid ? illegal_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_cpu6_ifid_buf.sv
// tb/tb_cpu6_ifid_buf.sv - directed self-checking bench for cpu6_ifid_buf
module tb_cpu6_ifid_buf;

    localparam logic [2:0] IT_NONE = 3'd0;
    localparam logic [2:0] IT_I    = 3'd1;
    localparam logic [2:0] IT_S    = 3'd2;
    localparam logic [2:0] IT_B    = 3'd3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        flush;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [2:0]  d_immtype;
    logic        d_illegal;

    int tests = 0;
    int fails = 0;

    cpu6_ifid_buf #(.DEPTH(2), .PTR_W(1), .CPU6_XLEN(32), .CPU6_BRANCHTYPE_SIZE(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .flush     (flush),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_immtype (d_immtype),
        .d_illegal (d_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; f_valid = 1'b0; f_instr = '0; f_pc = '0; flush = 1'b0; d_ready = 1'b0;
        step(); step();
        tests++;
        if ({d_valid, f_ready} !== 2'b00) begin
            fails++; $display("FAIL reset_handshake got v/r=%b%b exp 00", d_valid, f_ready);
        end
        tests++;
        if ({d_instr, d_pc, d_immtype, d_illegal} !== 68'd0) begin
            fails++; $display("FAIL reset_outputs got %h %h %h %b exp zeros", d_instr, d_pc, d_immtype, d_illegal);
        end
        resetn = 1'b1; settle();
        tests++;
        if ({d_valid, f_ready} !== 2'b01) begin
            fails++; $display("FAIL reset_release got v/r=%b%b exp 01", d_valid, f_ready);
        end
    endtask

    task automatic test_single_push();
        f_valid = 1'b1; f_instr = 32'h00500093; f_pc = 32'h100; d_ready = 1'b1; settle();
        tests++;
        if ({f_ready, d_valid} !== 2'b10) begin
            fails++; $display("FAIL single_push_cycle got r/v=%b%b exp 10", f_ready, d_valid);
        end
        step();
        f_valid = 1'b0; settle();
        tests++;
        if ({d_valid, d_instr, d_pc, d_immtype, d_illegal} !== {1'b1, 32'h00500093, 32'h100, IT_I, 1'b0}) begin
            fails++; $display("FAIL single_push_head got %b %h %h %h %b exp 1 00500093 00000100 1 0",
                              d_valid, d_instr, d_pc, d_immtype, d_illegal);
        end
        step();
        tests++;
        if ({d_valid, d_instr, d_pc, d_immtype, d_illegal} !== 69'd0) begin
            fails++; $display("FAIL single_push_empty got %b %h %h %h %b exp all zero",
                              d_valid, d_instr, d_pc, d_immtype, d_illegal);
        end
    endtask

    task automatic test_classification();
        logic [31:0] ins [4] = '{32'h0020A423, 32'hFE000EE3, 32'h002081B3, 32'h00000000};
        logic [2:0]  ity [4] = '{IT_S, IT_B, IT_NONE, IT_NONE};
        logic        ill [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                f_valid = 1'b1; f_instr = ins[i]; f_pc = 32'(4 * i);
            end else begin
                f_valid = 1'b0;
            end
            settle();
            if (i > 0) begin
                tests++;
                if ({d_valid, d_instr, d_pc, d_immtype, d_illegal} !==
                    {1'b1, ins[i-1], 32'(4 * (i-1)), ity[i-1], ill[i-1]}) begin
                    fails++; $display("FAIL classify_%0d got %b %h %h %h %b exp 1 %h %h %h %b", i-1,
                                      d_valid, d_instr, d_pc, d_immtype, d_illegal,
                                      ins[i-1], 32'(4 * (i-1)), ity[i-1], ill[i-1]);
                end
            end
            step();
        end
        tests++;
        if (d_valid !== 1'b0) begin
            fails++; $display("FAIL classify_drain got d_valid=%b exp 0", d_valid);
        end
    endtask

    task automatic test_backpressure();
        d_ready = 1'b0;
        f_valid = 1'b1; f_instr = 32'h00002083; f_pc = 32'h200; settle(); step();
        f_instr = 32'h0020A423; f_pc = 32'h204; settle();
        tests++;
        if (f_ready !== 1'b1) begin
            fails++; $display("FAIL bp_second_ready got %b exp 1", f_ready);
        end
        step();
        f_instr = 32'hFE000EE3; f_pc = 32'h208; settle();
        tests++;
        if ({f_ready, d_valid, d_pc} !== {1'b0, 1'b1, 32'h200}) begin
            fails++; $display("FAIL bp_full got r=%b v=%b pc=%h exp 0 1 00000200", f_ready, d_valid, d_pc);
        end
        step();
        d_ready = 1'b1; settle();
        tests++;
        if ({f_ready, d_pc, d_immtype} !== {1'b0, 32'h200, IT_I}) begin
            fails++; $display("FAIL bp_first_pop got r=%b pc=%h it=%h exp 0 00000200 1", f_ready, d_pc, d_immtype);
        end
        step();
        tests++;
        if ({f_ready, d_pc, d_immtype} !== {1'b1, 32'h204, IT_S}) begin
            fails++; $display("FAIL bp_second got r=%b pc=%h it=%h exp 1 00000204 2", f_ready, d_pc, d_immtype);
        end
        step();
        f_valid = 1'b0; settle();
        tests++;
        if ({d_valid, d_pc, d_instr, d_immtype} !== {1'b1, 32'h208, 32'hFE000EE3, IT_B}) begin
            fails++; $display("FAIL bp_third got v=%b pc=%h ins=%h it=%h exp 1 00000208 fe000ee3 3",
                              d_valid, d_pc, d_instr, d_immtype);
        end
        step();
        tests++;
        if (d_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drain got d_valid=%b exp 0", d_valid);
        end
    endtask

    task automatic test_push_pop();
        d_ready = 1'b0;
        f_valid = 1'b1; f_instr = 32'h00100113; f_pc = 32'h300; settle(); step();
        f_instr = 32'h002081B3; f_pc = 32'h304; d_ready = 1'b1; settle();
        tests++;
        if ({f_ready, d_valid, d_pc} !== {1'b1, 1'b1, 32'h300}) begin
            fails++; $display("FAIL pp_cycle got r=%b v=%b pc=%h exp 1 1 00000300", f_ready, d_valid, d_pc);
        end
        step();
        f_valid = 1'b0; d_ready = 1'b0; settle();
        tests++;
        if ({f_ready, d_valid, d_pc, d_immtype, d_illegal} !== {1'b1, 1'b1, 32'h304, IT_NONE, 1'b0}) begin
            fails++; $display("FAIL pp_advance got r=%b v=%b pc=%h it=%h ill=%b exp 1 1 00000304 0 0",
                              f_ready, d_valid, d_pc, d_immtype, d_illegal);
        end
        d_ready = 1'b1; step();
        tests++;
        if (d_valid !== 1'b0) begin
            fails++; $display("FAIL pp_count_one got d_valid=%b exp 0", d_valid);
        end
    endtask

    task automatic test_flush();
        d_ready = 1'b0;
        f_valid = 1'b1; f_instr = 32'h00000013; f_pc = 32'h400; settle(); step();
        f_pc = 32'h404; settle(); step();
        f_instr = 32'h0000006F; f_pc = 32'h408; flush = 1'b1; settle();
        tests++;
        if (f_ready !== 1'b0) begin
            fails++; $display("FAIL flush_cycle_ready got %b exp 0", f_ready);
        end
        step();
        flush = 1'b0; f_instr = 32'h00C00513; f_pc = 32'h500; settle();
        tests++;
        if ({d_valid, f_ready} !== 2'b01) begin
            fails++; $display("FAIL flush_empty got v/r=%b%b exp 01", d_valid, f_ready);
        end
        step();
        f_valid = 1'b0; settle();
        tests++;
        if ({d_valid, d_instr, d_pc} !== {1'b1, 32'h00C00513, 32'h500}) begin
            fails++; $display("FAIL flush_repush got v=%b ins=%h pc=%h exp 1 00c00513 00000500", d_valid, d_instr, d_pc);
        end
        d_ready = 1'b1; step();
        tests++;
        if (d_valid !== 1'b0) begin
            fails++; $display("FAIL flush_held_dropped got d_valid=%b pc=%h exp 0", d_valid, d_pc);
        end
    endtask

    task automatic test_reset_midstream();
        d_ready = 1'b0;
        f_valid = 1'b1; f_instr = 32'h00000013; f_pc = 32'h600; settle(); step();
        f_pc = 32'h604; settle(); step();
        f_valid = 1'b0; resetn = 1'b0; step();
        tests++;
        if ({d_valid, f_ready} !== 2'b00) begin
            fails++; $display("FAIL midreset_during got v/r=%b%b exp 00", d_valid, f_ready);
        end
        resetn = 1'b1; d_ready = 1'b1; settle();
        tests++;
        if ({d_valid, f_ready} !== 2'b01) begin
            fails++; $display("FAIL midreset_after got v/r=%b%b exp 01", d_valid, f_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (d_valid !== 1'b0) begin
                fails++; $display("FAIL midreset_stale_%0d got d_valid=%b pc=%h exp 0", i, d_valid, d_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_classification();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
